traffic_mode_arbiter: RTL and testbench

Parametrised successor to the two-bit traffic mode register. Arbitrates day/night, pedestrian and emergency requests into a registered `currentState`, adding:
- minimum dwell time
- sticky pedestrian requests
- timed pedestrian phase
- emergency preemption with a clearance hold

Sits between the sensor inputs and the light-sequencing controllers, which decode `currentState`.

---
 rtl/traffic_mode_arbiter.sv | 113 +++++++++++
 tb/tb_traffic_mode_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/traffic_mode_arbiter.sv
// Traffic mode arbiter: resolves day/night, pedestrian and emergency requests
// into a registered mode with dwell timing, sticky pedestrian requests and emergency clearance.
module traffic_mode_arbiter #(
    parameter int MIN_DWELL = 4,
    parameter int PED_HOLD  = 6,
    parameter int EMG_CLEAR = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       timeSignal,
    input  logic       pedSignal,
    input  logic       emgSignal,
    output logic [1:0] currentState,
    output logic       modeChange,
    output logic       pedPending
);

    localparam logic [1:0] ST_DAY   = 2'b00;
    localparam logic [1:0] ST_NIGHT = 2'b01;
    localparam logic [1:0] ST_PED   = 2'b10;
    localparam logic [1:0] ST_EMG   = 2'b11;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_HOLD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(EMG_CLEAR - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic             mode_change_q, mode_change_d;
    logic [1:0]       base_mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign base_mode = timeSignal ? ST_DAY : ST_NIGHT;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_DAY;
            cnt_q         <= '0;
            ped_pending_q <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            mode_change_q <= mode_change_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DAY, ST_NIGHT: begin
                if (emgSignal) begin
                    state_d = ST_EMG;
                end else if (cnt_q >= DWELL_LAST) begin
                    if (ped_pending_q) begin
                        state_d = ST_PED;
                    end else if (base_mode != state_q) begin
                        state_d = base_mode;
                    end
                end
            end
            ST_PED: begin
                if (emgSignal) begin
                    state_d = ST_EMG;
                end else if (cnt_q == PED_LAST) begin
                    state_d = base_mode;
                end
            end
            ST_EMG: begin
                if (!emgSignal && cnt_q == CLEAR_LAST) begin
                    state_d = ped_pending_q ? ST_PED : base_mode;
                end
            end
            default: state_d = ST_DAY;
        endcase
    end

    // Counter restarts on every mode change and stays parked while the emergency is present.
    always_comb begin
        cnt_d         = sat_inc(cnt_q);
        ped_pending_d = ped_pending_q;
        mode_change_d = (state_d != state_q);
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_EMG && emgSignal) begin
            cnt_d = '0;
        end

        if (state_q == ST_PED) begin
            if (emgSignal) begin
                ped_pending_d = 1'b1;
            end
        end else if (state_d == ST_PED) begin
            // A request seen on the EMG->PED entry edge survives; from DAY/NIGHT it is consumed.
            ped_pending_d = (state_q == ST_EMG) && pedSignal;
        end else if (pedSignal) begin
            ped_pending_d = 1'b1;
        end
    end

    always_comb begin
        currentState = state_q;
        modeChange   = mode_change_q;
        pedPending   = ped_pending_q;
    end

endmodule

// File: tb/tb_traffic_mode_arbiter.sv
// Scoreboard bench for traffic_mode_arbiter: directed per-cycle vectors push
// expected {state, modeChange, pedPending}; a monitor pops and compares after each edge.
module tb_traffic_mode_arbiter;

    logic       clk;
    logic       resetN;
    logic       timeSignal;
    logic       pedSignal;
    logic       emgSignal;
    logic [1:0] currentState;
    logic       modeChange;
    logic       pedPending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] st;
        logic       mc;
        logic       pd;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    traffic_mode_arbiter #(
        .MIN_DWELL(4),
        .PED_HOLD (6),
        .EMG_CLEAR(3),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .timeSignal  (timeSignal),
        .pedSignal   (pedSignal),
        .emgSignal   (emgSignal),
        .currentState(currentState),
        .modeChange  (modeChange),
        .pedPending  (pedPending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void compare(input string tag, input logic [1:0] st,
                                    input logic mc, input logic pd);
        checks++;
        if (currentState !== st || modeChange !== mc || pedPending !== pd) begin
            failures++;
            $display("FAIL %s: got state=%b modeChange=%b pedPending=%b, expected state=%b modeChange=%b pedPending=%b",
                     tag, currentState, modeChange, pedPending, st, mc, pd);
        end
    endfunction

    // Called at a negedge: drive inputs, queue the result expected after the next rising edge.
    task automatic step(input logic e, input logic p, input logic t,
                        input logic [1:0] st, input logic mc, input logic pd,
                        input string tag);
        exp_t x;
        emgSignal  = e;
        pedSignal  = p;
        timeSignal = t;
        x.st  = st;
        x.mc  = mc;
        x.pd  = pd;
        x.tag = tag;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                compare(x.tag, x.st, x.mc, x.pd);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        resetN     = 1'b1;
        timeSignal = 1'b0;
        pedSignal  = 1'b0;
        emgSignal  = 1'b0;
        #1 resetN = 1'b0;
        #2 compare("reset_async", 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Reset release at night: DAY for dwell, then NIGHT
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 0, 0, "rst_day_dwell");
        step(0, 0, 0, 2'b01, 1, 0, "night_entry");
        step(0, 0, 0, 2'b01, 0, 0, "night_mc_drop");
        step(0, 0, 1, 2'b01, 0, 0, "night_dwell");
        step(0, 0, 1, 2'b01, 0, 0, "night_dwell");
        step(0, 0, 1, 2'b00, 1, 0, "day_entry");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b00, 0, 0, "day_dwell");

        // Pedestrian service with a one-cycle pulse
        step(0, 1, 1, 2'b00, 0, 1, "ped_latch");
        step(0, 0, 1, 2'b10, 1, 0, "ped_entry");
        step(0, 0, 1, 2'b10, 0, 0, "ped_hold");
        step(0, 1, 1, 2'b10, 0, 0, "ped_ignored_in_ped");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b10, 0, 0, "ped_hold");
        step(0, 0, 1, 2'b00, 1, 0, "ped_exit_day");

        // Pulse during dwell is held until dwell expires
        step(0, 1, 1, 2'b00, 0, 1, "ped_latch_early");
        step(0, 0, 1, 2'b00, 0, 1, "ped_wait_dwell");
        step(0, 0, 1, 2'b00, 0, 1, "ped_wait_dwell");
        step(0, 0, 1, 2'b10, 1, 0, "ped_entry2");
        step(0, 0, 1, 2'b10, 0, 0, "ped_cycle2");

        // Emergency preempts pedestrian phase
        step(1, 0, 1, 2'b11, 1, 1, "emg_preempt_ped");
        for (int i = 0; i < 4; i++) step(1, 0, 1, 2'b11, 0, 1, "emg_active");
        step(0, 0, 0, 2'b11, 0, 1, "emg_clear1");
        step(0, 0, 0, 2'b11, 0, 1, "emg_clear2");
        step(0, 0, 0, 2'b10, 1, 0, "emg_exit_ped");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b10, 0, 0, "ped_reservice");
        step(0, 0, 0, 2'b01, 1, 0, "ped_exit_night");

        // Clearance restart on re-assertion
        step(1, 0, 0, 2'b11, 1, 0, "emg_from_night");
        step(0, 0, 0, 2'b11, 0, 0, "clear_low1");
        step(0, 0, 0, 2'b11, 0, 0, "clear_low2");
        step(1, 0, 0, 2'b11, 0, 0, "clear_restart");
        step(0, 0, 0, 2'b11, 0, 0, "clear2_low1");
        step(0, 0, 0, 2'b11, 0, 0, "clear2_low2");
        step(0, 0, 0, 2'b01, 1, 0, "clear_exit_night");

        // Simultaneous ped+emg in DAY at cnt=0
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b01, 0, 0, "night_dwell2");
        step(0, 0, 1, 2'b00, 1, 0, "day_entry2");
        step(1, 1, 1, 2'b11, 1, 1, "simul_req");
        step(0, 0, 1, 2'b11, 0, 1, "simul_clear1");
        step(0, 0, 1, 2'b11, 0, 1, "simul_clear2");
        step(0, 1, 1, 2'b10, 1, 1, "emg_exit_set_prio");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 2'b10, 0, 1, "ped_hold_pending");
        step(0, 0, 1, 2'b00, 1, 1, "ped_exit_pending");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b00, 0, 1, "day_dwell_pending");
        step(0, 0, 1, 2'b10, 1, 0, "ped_again");
        step(1, 0, 1, 2'b11, 1, 1, "emg_preempt2");

        // Asynchronous reset mid-EMG, then dwell restarts from zero
        #2 resetN = 1'b0;
        #1 compare("reset_mid_emg", 2'b00, 1'b0, 1'b0);
        emgSignal = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 0, 0, "rst2_day_dwell");
        step(0, 0, 0, 2'b01, 1, 0, "rst2_night_entry");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
